spram_be_ctrl: RTL and testbench
================================

SPRAM_BE_CTRL -- requirements
Module: spram_be_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have port clock_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both 1.
REQ-007 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-009 SHALL have port req_be, input, DATA_WIDTH/8, byte enables; bit i enables byte i.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port rsp_valid, output, 1, read data available.
REQ-012 SHALL have port rsp_ready, input, 1, consumer takes rsp_data when rsp_valid and rsp_ready are both 1.
REQ-013 SHALL have port rsp_data, output, DATA_WIDTH, read data.
REQ-014 SHALL have ports mem_address (ADDR_WIDTH), mem_byteena (DATA_WIDTH/8), mem_data (DATA_WIDTH) and mem_wren (1), all outputs to the byte-enable single-port RAM.
REQ-015 SHALL have port mem_q, input, DATA_WIDTH, RAM read data, valid exactly 1 cycle after the address is presented.

Function
REQ-016 SHALL define accept = req_valid & req_ready.
REQ-017 SHALL drive the memory port outputs combinationally from the request:
- mem_address = req_addr.
- mem_data = req_wdata.
- mem_wren = accept & req_write.
- mem_byteena = req_be when mem_wren = 1, else all zeros.
REQ-018 SHALL treat an accepted write as complete on acceptance; writes produce no response.
REQ-019 SHALL accept a write with req_be = 0 as a no-op; no memory byte changes.
REQ-020 SHALL set a registered flag inflight to 1 on the edge that accepts a read, and to 0 otherwise.
REQ-021 SHALL capture mem_q into a 3-entry response FIFO on the edge following a cycle in which inflight = 1.
REQ-022 SHALL give read latency exactly 2 cycles: read accepted at edge N -> rsp_valid = 1 after edge N+1 when the FIFO was empty.
REQ-023 SHALL compute req_ready = (inflight + fifo_count) < 3, from registered state only, with no combinational path from rsp_ready or req_valid.
REQ-024 SHALL apply the req_ready gate to writes as well as reads.
REQ-025 SHALL drive rsp_valid = (fifo_count != 0) and rsp_data = FIFO head.
REQ-026 SHALL pop the FIFO on rsp_valid & rsp_ready.
REQ-027 SHALL perform push and pop in the same cycle without changing fifo_count.
REQ-028 SHALL wrap FIFO pointers modulo 3.
REQ-029 SHALL hold rsp_data and rsp_valid stable while rsp_valid = 1 and rsp_ready = 0.
REQ-030 SHALL return responses in request order.
REQ-031 SHALL sustain one read per cycle indefinitely while rsp_ready = 1.
REQ-032 SHALL, for a read followed next cycle by a write to the same address, return pre-write data (read-first ordering).
REQ-033 SHALL, for a write followed by a read to the same address, return post-write data.
REQ-034 SHALL never overflow the FIFO; the credit rule in REQ-023 guarantees space for every inflight read.

Reset
REQ-035 SHALL, while reset_in = 1, asynchronously clear inflight, fifo_count and the FIFO pointers.
REQ-036 SHALL, while reset_in = 1, drive rsp_valid = 0, rsp_data = 0 and req_ready = 0.
REQ-037 SHALL discard any inflight read and buffered responses on reset mid-operation; no stale response appears after reset.
REQ-038 SHALL, after release of reset_in, assert req_ready = 1 on the first clock_in edge.

Verification
REQ-039 Write 0xAABBCCDD to addr 5 with be=1111, then read addr 5 -> rsp_data = 0xAABBCCDD 2 cycles after read accept.
REQ-040 Write 0x11223344 to addr 5 with be=0101, then read addr 5 -> rsp_data = 0xAA22CC44.
REQ-041 Back-to-back reads of addrs 0..15 with rsp_ready = 1 -> req_ready stays 1 and 16 in-order responses arrive on consecutive cycles.
REQ-042 rsp_ready = 0 while issuing reads -> exactly 3 reads accepted, then req_ready = 0 and rsp_data held; raising rsp_ready drains 3 responses in order and req_ready returns to 1.
REQ-043 Read addr 7 followed next cycle by a write of 0x0 to addr 7 -> the read returns the old value; a later read returns 0x0.
REQ-044 reset_in pulsed with 2 responses buffered and 1 read inflight -> rsp_valid = 0 immediately and no response emitted after release.

Source files
------------

// File: rtl/spram_be_ctrl.sv
// Request/response front end for a byte-enable single-port RAM with 1-cycle read latency.
// Read data is buffered in a 3-entry FIFO; credits gate acceptance so every inflight read has a slot.
module spram_be_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_byteena,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    mem_wren,
    input  logic [DATA_WIDTH-1:0]   mem_q
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 3;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  inflight;
    logic                  ready_en;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            fifo_count;
    logic [2:0]            credits_used;
    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign accept       = req_valid & req_ready;
    assign push         = inflight;
    assign pop          = rsp_valid & rsp_ready;
    assign credits_used = {2'b00, inflight} + {1'b0, fifo_count};

    // ready_en keeps req_ready low during reset and raises it on the first edge after release
    assign req_ready = ready_en & (credits_used < 3'(DEPTH));

    assign mem_address = req_addr;
    assign mem_data    = req_wdata;
    assign mem_wren    = accept & req_write;
    assign mem_byteena = mem_wren ? req_be : {BE_W{1'b0}};

    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : {DATA_WIDTH{1'b0}};

    // Stage 0 -> 1: request accepted, RAM output captured into the FIFO one cycle later
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            ready_en   <= 1'b0;
            inflight   <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            ready_en <= 1'b1;
            inflight <= accept & ~req_write;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_q;
        end
    end

endmodule

// File: tb/tb_spram_be_ctrl.sv
// Directed bench for spram_be_ctrl with a behavioural byte-enable RAM (read-first, 1-cycle latency).
module tb_spram_be_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;
    localparam int NW = 1 << AW;

    logic          clock_in;
    logic          reset_in;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_be;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteena;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    logic          ram_init;
    logic [DW-1:0] ram    [NW];
    logic [DW-1:0] shadow [NW];

    int n_vec;
    int n_err;

    spram_be_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_be      (req_be),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .mem_address (mem_address),
        .mem_byteena (mem_byteena),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clock_in = ~clock_in;

    // Read-first RAM: q takes the old word when a write hits the same address on the same edge
    always @(posedge clock_in) begin
        if (ram_init) begin
            for (int i = 0; i < NW; i++) ram[i] <= 32'h1000_0000 + i * 32'h0000_0101;
        end else if (mem_wren) begin
            for (int b = 0; b < BW; b++)
                if (mem_byteena[b]) ram[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
        end
        mem_q <= ram[mem_address];
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int addr, input logic [BW-1:0] be, input logic [DW-1:0] data,
                            input string tag);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = AW'(addr);
        req_be    = be;
        req_wdata = data;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int b = 0; b < BW; b++)
            if (be[b]) shadow[addr][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic do_read(input int addr, input string tag);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = AW'(addr);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        check({tag, "_lat2_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_data, shadow[addr]);
        tick();
        check({tag, "_popped"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        clock_in  = 1'b0;
        reset_in  = 1'b1;
        ram_init  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NW; i++) shadow[i] = 32'h1000_0000 + i * 32'h0000_0101;

        tick();
        tick();
        ram_init = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        reset_in = 1'b0;
        check("rel_ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        check("rel_ready_first_edge", 32'(req_ready), 32'd1);

        // full write then read back, partial write, zero-enable write
        do_write(5, 4'b1111, 32'hAABBCCDD, "wr_full");
        do_read(5, "rd_full");
        check("rd_full_const", shadow[5], 32'hAABBCCDD);
        do_write(5, 4'b0101, 32'h11223344, "wr_part");
        req_valid = 1'b1;
        req_addr  = 10'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check("rd_part_data", rsp_data, 32'hAA22CC44);
        tick();
        do_write(5, 4'b0000, 32'hFFFFFFFF, "wr_be0");
        do_read(5, "rd_be0");

        // back-to-back stream, one response per cycle
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(i);
            check($sformatf("stream_ready_%0d", i), 32'(req_ready), 32'd1);
            tick();
            if (i > 0) begin
                check($sformatf("stream_valid_%0d", i - 1), 32'(rsp_valid), 32'd1);
                check($sformatf("stream_data_%0d", i - 1), rsp_data, shadow[i-1]);
            end
        end
        req_valid = 1'b0;
        tick();
        check("stream_valid_15", 32'(rsp_valid), 32'd1);
        check("stream_data_15", rsp_data, shadow[15]);
        tick();
        check("stream_drained", 32'(rsp_valid), 32'd0);

        // backpressure: exactly three reads accepted, head held
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(20 + i);
            check($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'd1);
            tick();
        end
        req_addr = 10'd23;
        check("bp_full_ready", 32'(req_ready), 32'd0);
        check("bp_head_a", rsp_data, shadow[20]);
        tick();
        check("bp_full_ready2", 32'(req_ready), 32'd0);
        check("bp_head_b", rsp_data, shadow[20]);
        tick();
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_head_c", rsp_data, shadow[20]);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_drain_0", rsp_data, shadow[20]);
        tick();
        check("bp_drain_1", rsp_data, shadow[21]);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        tick();
        check("bp_drain_2", rsp_data, shadow[22]);
        tick();
        check("bp_empty", 32'(rsp_valid), 32'd0);

        // read followed immediately by a write to the same address
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'd7;
        tick();
        req_write = 1'b1;
        req_be    = 4'b1111;
        req_wdata = 32'h0;
        check("rfw_wr_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        check("rfw_old_valid", 32'(rsp_valid), 32'd1);
        check("rfw_old_data", rsp_data, 32'h1000_0707);
        shadow[7] = 32'h0;
        tick();
        do_read(7, "rfw_new");

        // reset with two responses buffered and one read inflight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(30 + i);
            tick();
        end
        req_valid = 1'b0;
        check("mid_buffered", 32'(rsp_valid), 32'd1);
        reset_in = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        reset_in  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("mid_rel_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_no_stale_%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        do_read(31, "post_rst_read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
